// File: rtl/id_issue_ctrl.sv
// Issue controller for the decode stage. Each cycle it decides whether the
// instruction in ID moves into EX, tracks in-flight long-latency writebacks
// in a per-register scoreboard, and inserts a bubble after a flush.
//
// Handshake: instr_valid_i says IF-ID holds an instruction. instr_ready_o says
// ID consumes it this cycle, either by issuing it (issue_valid_o, which needs
// ex_ready_i) or by dropping it on flush_i. stall_o marks a valid instruction
// that is held.
module id_issue_ctrl #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             instr_valid_i,
   output logic             instr_ready_o,
   input  logic [4:0]       rs1_addr_i,
   input  logic [4:0]       rs2_addr_i,
   input  logic [4:0]       rd_addr_i,
   input  logic             uses_rs1_i,
   input  logic             uses_rs2_i,
   input  logic             writes_rd_i,
   input  logic             long_lat_i,
   input  logic             is_fence_i,
   input  logic             ex_ready_i,
   output logic             issue_valid_o,
   input  logic             wb_valid_i,
   input  logic [4:0]       wb_addr_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic [31:0]      pending_o,
   output logic [CNT_W-1:0] outstanding_o,
   output logic             spurious_wb_o
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_BUBBLE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        pending_q, pending_d;
   logic [CNT_W-1:0]   outstanding_q, outstanding_d;
   logic               spurious_q, spurious_d;

   logic               hz;
   logic               full;
   logic               fence_blk;
   logic               issue;
   logic               consume;
   logic               track;
   logic               wb_hit;
   logic [31:0]        set_mask;
   logic [31:0]        clr_mask;

   // Hazard and issue decision; hazards look only at the registered
   // scoreboard, so a same-cycle writeback releases the stall one cycle later.
   always_comb begin
      hz = (uses_rs1_i  && (rs1_addr_i != 5'd0) && pending_q[rs1_addr_i]) ||
           (uses_rs2_i  && (rs2_addr_i != 5'd0) && pending_q[rs2_addr_i]) ||
           (writes_rd_i && (rd_addr_i  != 5'd0) && pending_q[rd_addr_i]);
      full = long_lat_i && writes_rd_i && (rd_addr_i != 5'd0) &&
             (outstanding_q == CNT_W'(MAX_OUTSTANDING));
      fence_blk = is_fence_i && (outstanding_q != '0);
      issue = (state_q == ST_RUN) && instr_valid_i && ex_ready_i && !flush_i &&
              !hz && !full && !fence_blk;
      consume = issue || (flush_i && instr_valid_i);
   end

   // Handshake outputs, held low while reset is asserted.
   always_comb begin
      issue_valid_o = rst_ni && issue;
      instr_ready_o = rst_ni && consume;
      stall_o       = rst_ni && instr_valid_i && !consume;
   end

   // Scoreboard update: set on tracked issue, clear on a matching writeback.
   // x0 is never tracked, so a writeback to x0 always counts as spurious.
   always_comb begin
      track    = issue && long_lat_i && writes_rd_i && (rd_addr_i != 5'd0);
      wb_hit   = wb_valid_i && pending_q[wb_addr_i];
      set_mask = track  ? (32'd1 << rd_addr_i) : 32'd0;
      clr_mask = wb_hit ? (32'd1 << wb_addr_i) : 32'd0;
      pending_d = ((pending_q & ~clr_mask) | set_mask) & ~32'd1;
      outstanding_d = outstanding_q;
      case ({track, wb_hit})
         2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
         2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase
      spurious_d = wb_valid_i && !pending_q[wb_addr_i];
   end

   // Next-state logic; a flush overrides every other transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:    if (instr_valid_i && fence_blk) state_d = ST_DRAIN;
         ST_BUBBLE: state_d = ST_RUN;
         ST_DRAIN:  if (outstanding_q == '0) state_d = ST_RUN;
         default:   state_d = ST_RUN;
      endcase
      if (flush_i) state_d = ST_BUBBLE;
   end

   // State, scoreboard and pulse registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_RUN;
         pending_q     <= 32'd0;
         outstanding_q <= '0;
         spurious_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         outstanding_q <= outstanding_d;
         spurious_q    <= spurious_d;
      end
   end

   // Registered status outputs.
   always_comb begin
      pending_o     = pending_q;
      outstanding_o = outstanding_q;
      spurious_wb_o = spurious_q;
   end

endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
- Issue controller for the milano decode stage. It sits between the IF-ID pipeline register and the ID-EX pipeline register.
- It decides each cycle whether the decoded instruction may issue to EX.
- It tracks outstanding long-latency writebacks (load/mul/div) in a per-register scoreboard, and stalls on RAW/WAW hazards, on a full outstanding queue, and on fences.
- It inserts a one-cycle bubble after a branch/exception flush.

Parameters:
- MAX_OUTSTANDING, 4, max number of in-flight long-latency ops (1..31).
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter.

Ports:
- clk_i, input, 1, core clock.
- rst_ni, input, 1, reset. Asynchronous, active-low.
- instr_valid_i, input, 1, IF-ID register holds a valid instruction.
- instr_ready_o, output, 1, ID consumes the instruction this cycle (issued or flushed).
- rs1_addr_i, input, 5, decoded source register 1.
- rs2_addr_i, input, 5, decoded source register 2.
- rd_addr_i, input, 5, decoded destination register.
- uses_rs1_i, input, 1, instruction reads rs1.
- uses_rs2_i, input, 1, instruction reads rs2.
- writes_rd_i, input, 1, instruction writes rd.
- long_lat_i, input, 1, result returns via the late writeback port.
- is_fence_i, input, 1, instruction is FENCE/FENCE.I.
- ex_ready_i, input, 1, ID-EX register can accept.
- issue_valid_o, output, 1, load ID-EX register with the current instruction.
- wb_valid_i, input, 1, long-latency writeback completes this cycle.
- wb_addr_i, input, 5, register written by that writeback.
- flush_i, input, 1, branch taken / exception: drop instruction in ID.
- stall_o, output, 1, instr_valid_i high but not consumed.
- pending_o, output, 32, scoreboard bitmap (bit n = xn pending).
- outstanding_o, output, CNT_W, count of in-flight long-latency ops.
- spurious_wb_o, output, 1, one-cycle pulse: writeback to a non-pending register.

Behaviour:
- Reset (rst_ni low, async): state=RUN, pending=0, outstanding=0, spurious_wb_o=0. issue_valid_o, instr_ready_o and stall_o are forced 0 while in reset.
- States:
  - RUN: normal issue.
  - BUBBLE: one cycle after flush.
  - DRAIN: fence waiting for outstanding==0.
- hz = (uses_rs1_i & rs1!=0 & pending[rs1]) | (uses_rs2_i & rs2!=0 & pending[rs2]) | (writes_rd_i & rd!=0 & pending[rd]).
  - Evaluated against registered pending only.
  - A writeback in the same cycle does not clear the hazard; the clear takes effect the next cycle.
- full = long_lat_i & writes_rd_i & rd!=0 & outstanding==MAX_OUTSTANDING.
- fence_blk = is_fence_i & outstanding!=0.
- issue_valid_o = state==RUN & instr_valid_i & ex_ready_i & !flush_i & !hz & !full & !fence_blk.
- instr_ready_o = issue_valid_o | (flush_i & instr_valid_i).
- stall_o = instr_valid_i & !instr_ready_o.
- Transitions:
  - Any state with flush_i → BUBBLE (flush has priority over everything).
  - RUN with instr_valid_i & fence_blk → DRAIN.
  - DRAIN: when outstanding==0 → RUN. The fence then issues on the following cycle.
  - BUBBLE → RUN unconditionally after 1 cycle; no issue occurs in BUBBLE.
- Track on issue: when issue & long_lat_i & writes_rd_i & rd!=0, set pending[rd] and increment outstanding. Long-latency ops targeting x0 are not tracked.
- Writeback: when wb_valid_i & pending[wb_addr], clear the bit and decrement outstanding.
  - When wb_valid_i & !pending[wb_addr] (including x0): state unchanged, spurious_wb_o=1 for the next cycle only.
- Simultaneous set and clear on different registers: both applied, outstanding net unchanged. The same register cannot be set and cleared together, because the WAW check blocks issue.
- Flush does not clear pending/outstanding; already-issued ops still write back.
- Counter never wraps. outstanding==popcount(pending) always; the verifier asserts this.
- pending[0] is always 0.

Test Plan:
- Reset, then instr_valid_i=1, no hazards, ex_ready_i=1 → issue_valid_o=1 same cycle, pending_o=0.
- Issue long-lat load to x5, next instr uses rs1=x5 → stall_o=1. Assert wb_valid_i/wb_addr_i=5 in cycle N → stall_o still 1 in N, issue in N+1, pending_o=0.
- Issue 4 long-lat ops to x1..x4 (MAX=4), fifth to x6 → blocked with outstanding_o=4. A writeback on x2 → fifth issues next cycle, outstanding_o=4, pending_o=0x5A.
- Fence with outstanding_o=2 → DRAIN, stall_o=1. Writebacks drain to 0 → fence issues one cycle later.
- flush_i with instr_valid_i=1 during a stall → instr_ready_o=1, issue_valid_o=0. Next cycle (BUBBLE) issue_valid_o=0 despite a valid instr; pending_o is preserved.
- wb_valid_i with wb_addr_i=7 not pending → spurious_wb_o pulses 1 cycle, outstanding_o unchanged. Assert rst_ni low mid-DRAIN → immediate RUN, pending_o=0, outstanding_o=0.
